// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared state encoding and default width for the serial compare feeder.
package serial_cmp_pkg;
    localparam int SERIAL_CMP_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CLEAR   = 2'b01,
        SHIFT   = 2'b10,
        CAPTURE = 2'b11
    } state_e;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, right-shifting register presenting its LSB on q.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);
    logic [WIDTH-1:0] sh_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) sh_q <= '0;
        else if (load) sh_q <= d;
        else if (shift) sh_q <= {1'b0, sh_q[WIDTH-1:1]};
    assign q = sh_q[0];
endmodule

// File: rtl/serial_compare_feeder.sv
// serial_compare_feeder: streams two operands LSB-first into a bit-serial comparator
// and registers its final greater/equal/less verdict.
module serial_compare_feeder
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = SERIAL_CMP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             ser_a,
    output logic             ser_b,
    output logic             cmp_clear,
    input  logic             cmp_greater,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    output logic             res_valid,
    output logic             res_greater,
    output logic             res_equal,
    output logic             res_less
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, ser_a_q, ser_b_q, clear_q;
    logic             res_valid_q, res_greater_q, res_equal_q, res_less_q;
    logic             load, shift, sh_a, sh_b;
    assign load  = (state_q == IDLE) && start;
    // Shifting already in CLEAR means the register's LSB is always one bit ahead of ser_*
    assign shift = (state_q == CLEAR) || (state_q == SHIFT);
    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk(clk), .reset(reset), .load(load), .shift(shift), .d(op_a), .q(sh_a)
    );
    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk(clk), .reset(reset), .load(load), .shift(shift), .d(op_b), .q(sh_b)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            ser_a_q       <= 1'b0;
            ser_b_q       <= 1'b0;
            clear_q       <= 1'b1;
            res_valid_q   <= 1'b0;
            res_greater_q <= 1'b0;
            res_equal_q   <= 1'b0;
            res_less_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    state_q <= SHIFT;
                    clear_q <= 1'b0;
                    ser_a_q <= sh_a;
                    ser_b_q <= sh_b;
                end
                SHIFT: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == LAST) ? CAPTURE : SHIFT;
                    ser_a_q <= (cnt_q == LAST) ? 1'b0 : sh_a;
                    ser_b_q <= (cnt_q == LAST) ? 1'b0 : sh_b;
                end
                CAPTURE: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    clear_q       <= 1'b1;
                    res_valid_q   <= 1'b1;
                    res_greater_q <= cmp_greater;
                    res_equal_q   <= cmp_equal;
                    res_less_q    <= cmp_less;
                end
            endcase
        end
    end
    assign busy        = busy_q;
    assign ser_a       = ser_a_q;
    assign ser_b       = ser_b_q;
    assign cmp_clear   = clear_q;
    assign res_valid   = res_valid_q;
    assign res_greater = res_greater_q;
    assign res_equal   = res_equal_q;
    assign res_less    = res_less_q;
endmodule

// File: tb/tb_serial_compare_feeder.sv
// tb_serial_compare_feeder: drives the feeder into a behavioural serial comparator and
// checks serial streams, timing and results against a scoreboard of expected verdicts.
module tb_serial_compare_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       busy, ser_a, ser_b, cmp_clear, cmp_greater, cmp_equal, cmp_less;
    logic       res_valid, res_greater, res_equal, res_less;
    logic       start2 = 1'b0;
    logic [1:0] op_a2 = '0, op_b2 = '0;
    logic       busy2, ser_a2, ser_b2, cmp_clear2, cmp_greater2, cmp_equal2, cmp_less2;
    logic       res_valid2, res_greater2, res_equal2, res_less2;
    logic       g_q, l_q, g2_q, l2_q;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] sb8[$];
    logic [2:0] sb2[$];

    always #5 clk = ~clk;

    serial_compare_feeder #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .ser_a(ser_a), .ser_b(ser_b), .cmp_clear(cmp_clear),
        .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
        .res_valid(res_valid), .res_greater(res_greater), .res_equal(res_equal),
        .res_less(res_less)
    );

    serial_compare_feeder #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op_a(op_a2), .op_b(op_b2),
        .busy(busy2), .ser_a(ser_a2), .ser_b(ser_b2), .cmp_clear(cmp_clear2),
        .cmp_greater(cmp_greater2), .cmp_equal(cmp_equal2), .cmp_less(cmp_less2),
        .res_valid(res_valid2), .res_greater(res_greater2), .res_equal(res_equal2),
        .res_less(res_less2)
    );

    // Bit-serial comparator: a differing bit overrides whatever earlier bits decided.
    always @(posedge clk) begin
        if (cmp_clear) begin
            g_q <= 1'b0;
            l_q <= 1'b0;
        end else if (ser_a != ser_b) begin
            g_q <= ser_a;
            l_q <= ser_b;
        end
        if (cmp_clear2) begin
            g2_q <= 1'b0;
            l2_q <= 1'b0;
        end else if (ser_a2 != ser_b2) begin
            g2_q <= ser_a2;
            l2_q <= ser_b2;
        end
    end
    assign cmp_greater  = g_q;
    assign cmp_less     = l_q;
    assign cmp_equal    = ~g_q & ~l_q;
    assign cmp_greater2 = g2_q;
    assign cmp_less2    = l2_q;
    assign cmp_equal2   = ~g2_q & ~l2_q;

    function automatic logic [2:0] exp_of(input int a, input int b);
        return {a > b, a == b, a < b};
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, ser_a, ser_b, cmp_clear, res_valid, res_greater, res_equal, res_less} !== 8'b0001_0000)
            begin errors++; $display("FAIL reset8: got %b want 00010000",
                {busy, ser_a, ser_b, cmp_clear, res_valid, res_greater, res_equal, res_less}); end
        checks++;
        if ({busy2, ser_a2, ser_b2, cmp_clear2, res_valid2, res_greater2, res_equal2, res_less2} !== 8'b0001_0000)
            begin errors++; $display("FAIL reset2: got %b want 00010000",
                {busy2, ser_a2, ser_b2, cmp_clear2, res_valid2, res_greater2, res_equal2, res_less2}); end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] a = 8'hA5;
        logic [7:0] b = 8'h3C;
        logic [2:0] e;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b;
        sb8.push_back(exp_of(int'(a), int'(b)));
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, cmp_clear, ser_a, ser_b} !== 4'b1100)
            begin errors++; $display("FAIL stream_clear: got %b want 1100", {busy, cmp_clear, ser_a, ser_b}); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ser_a, ser_b, cmp_clear, busy} !== {a[i], b[i], 2'b01})
                begin errors++; $display("FAIL stream_bit%0d: got %b want %b", i,
                    {ser_a, ser_b, cmp_clear, busy}, {a[i], b[i], 2'b01}); end
        end
        @(posedge clk); #1;
        checks++;
        if ({ser_a, ser_b, cmp_clear, busy, res_valid} !== 5'b00010)
            begin errors++; $display("FAIL stream_capture: got %b want 00010",
                {ser_a, ser_b, cmp_clear, busy, res_valid}); end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1)
            begin errors++; $display("FAIL stream_valid_E10: got %b want 1", res_valid); end
        if (res_valid === 1'b1 && sb8.size() > 0) begin
            e = sb8.pop_front();
            checks++;
            if ({res_greater, res_equal, res_less} !== e)
                begin errors++; $display("FAIL stream_result: got %b want %b",
                    {res_greater, res_equal, res_less}, e); end
        end
        sb8.delete();
    endtask

    task automatic test_equal();
        logic [2:0] e;
        int k = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h5A; op_b = 8'h5A;
        sb8.push_back(exp_of(8'h5A, 8'h5A));
        @(posedge clk); #1;
        start = 1'b0;
        while (res_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        checks++;
        if (k != 10) begin errors++; $display("FAIL equal_latency: got %0d want 10", k); end
        if (res_valid === 1'b1 && sb8.size() > 0) begin
            e = sb8.pop_front();
            checks++;
            if ({res_greater, res_equal, res_less} !== e)
                begin errors++; $display("FAIL equal_result: got %b want %b", {res_greater, res_equal, res_less}, e); end
        end
        @(posedge clk); #1;
        checks++;
        if ({res_valid, res_greater, res_equal, res_less} !== 4'b0010)
            begin errors++; $display("FAIL equal_pulse_hold: got %b want 0010",
                {res_valid, res_greater, res_equal, res_less}); end
        sb8.delete();
    endtask

    task automatic test_msb_lsb();
        logic [7:0] av[2] = '{8'h00, 8'h01};
        logic [7:0] bv[2] = '{8'h80, 8'h00};
        logic [2:0] e;
        for (int t = 0; t < 2; t++) begin
            int k = 0;
            @(posedge clk); #1;
            start = 1'b1; op_a = av[t]; op_b = bv[t];
            sb8.push_back(exp_of(int'(av[t]), int'(bv[t])));
            @(posedge clk); #1;
            start = 1'b0;
            while (res_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
            checks++;
            if (k != 10) begin errors++; $display("FAIL edge%0d_latency: got %0d want 10", t, k); end
            if (res_valid === 1'b1 && sb8.size() > 0) begin
                e = sb8.pop_front();
                checks++;
                if ({res_greater, res_equal, res_less} !== e)
                    begin errors++; $display("FAIL edge%0d_result: got %b want %b", t,
                        {res_greater, res_equal, res_less}, e); end
            end
            sb8.delete();
        end
    endtask

    task automatic test_start_held();
        logic [2:0] e;
        int k = 0;
        logic busy_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h01; op_b = 8'h02;
        sb8.push_back(exp_of(8'h01, 8'h02));
        sb8.push_back(exp_of(8'hFF, 8'h00));
        @(posedge clk); #1;
        op_a = 8'hFF; op_b = 8'h00;
        while (res_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        checks++;
        if (k != 10 || busy !== 1'b0)
            begin errors++; $display("FAIL held_first: got latency %0d busy %b want 10 0", k, busy); end
        if (res_valid === 1'b1 && sb8.size() > 0) begin
            e = sb8.pop_front();
            checks++;
            if ({res_greater, res_equal, res_less} !== e)
                begin errors++; $display("FAIL held_first_result: got %b want %b", {res_greater, res_equal, res_less}, e); end
        end
        @(posedge clk); #1; k++;
        busy_seen = busy;
        while (res_valid !== 1'b1 && k < 60) begin @(posedge clk); #1; k++; end
        start = 1'b0;
        checks++;
        if (k != 21 || busy_seen !== 1'b1)
            begin errors++; $display("FAIL held_second: got latency %0d busy %b want 21 1", k, busy_seen); end
        if (res_valid === 1'b1 && sb8.size() > 0) begin
            e = sb8.pop_front();
            checks++;
            if ({res_greater, res_equal, res_less} !== e)
                begin errors++; $display("FAIL held_second_result: got %b want %b", {res_greater, res_equal, res_less}, e); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, res_valid} !== 2'b00)
            begin errors++; $display("FAIL held_no_third: got %b want 00", {busy, res_valid}); end
        sb8.delete();
    endtask

    task automatic test_reset_abort();
        logic [2:0] e;
        int k = 0;
        int pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h33; op_b = 8'h44;
        sb8.push_back(exp_of(8'h33, 8'h44));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        sb8.delete();
        checks++;
        if ({busy, ser_a, ser_b, cmp_clear, res_valid, res_greater, res_equal, res_less} !== 8'b0001_0000)
            begin errors++; $display("FAIL abort_async: got %b want 00010000",
                {busy, ser_a, ser_b, cmp_clear, res_valid, res_greater, res_equal, res_less}); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) reset = 1'b1;
            if (res_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || cmp_clear !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_quiet: got pulses %0d clear %b busy %b want 0 1 0",
                pulses, cmp_clear, busy); end
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'h10; op_b = 8'h20;
        sb8.push_back(exp_of(8'h10, 8'h20));
        @(posedge clk); #1;
        start = 1'b0;
        while (res_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        checks++;
        if (k != 10) begin errors++; $display("FAIL abort_recover_latency: got %0d want 10", k); end
        if (res_valid === 1'b1 && sb8.size() > 0) begin
            e = sb8.pop_front();
            checks++;
            if ({res_greater, res_equal, res_less} !== e)
                begin errors++; $display("FAIL abort_recover_result: got %b want %b",
                    {res_greater, res_equal, res_less}, e); end
        end
        sb8.delete();
    endtask

    task automatic test_width2();
        logic [2:0] e;
        logic [3:0] bits = '0;
        int k = 0;
        int low_clear = 0;
        @(posedge clk); #1;
        start2 = 1'b1; op_a2 = 2'b10; op_b2 = 2'b01;
        sb2.push_back(exp_of(2, 1));
        @(posedge clk); #1;
        start2 = 1'b0;
        while (res_valid2 !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
            if (cmp_clear2 === 1'b0) low_clear++;
            if (k == 1 || k == 2) bits = {bits[1:0], ser_a2, ser_b2};
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL w2_latency: got %0d want 4", k); end
        checks++;
        if (low_clear != 3 || bits !== 4'b0110)
            begin errors++; $display("FAIL w2_shift: got clear-low %0d bits %b want 3 0110", low_clear, bits); end
        if (res_valid2 === 1'b1 && sb2.size() > 0) begin
            e = sb2.pop_front();
            checks++;
            if ({res_greater2, res_equal2, res_less2} !== e)
                begin errors++; $display("FAIL w2_result: got %b want %b", {res_greater2, res_equal2, res_less2}, e); end
        end
        sb2.delete();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_equal();
        test_msb_lsb();
        test_start_held();
        test_reset_abort();
        test_width2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
